// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between speculative loads and committed stores,
// one transaction in flight. Optional perf counters: define DMEM_ARB_PERF_EN.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_rmask,
  output logic        ld_ready,
  input  logic        ld_flush,
  output logic        ld_resp_valid,
  output logic [31:0] ld_rdata,
  input  logic        st_empty,
  input  logic        st_full,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_wmask,
  input  logic [31:0] st_wdata,
  output logic        st_ren,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_ld_cnt,
  output logic [31:0] perf_st_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt, w_starve_nxt;
  logic              r_kill, w_kill_nxt;
  logic [31:0]       r_addr, w_addr_nxt;
  logic [3:0]        r_rmask, w_rmask_nxt;
  logic [3:0]        r_wmask, w_wmask_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              w_st_pend, w_ld_vld, w_st_grant, w_ld_grant;
  logic              w_unused_bits;

  assign w_st_pend     = !st_empty;
  assign w_ld_vld      = ld_req && !ld_flush;
  assign w_unused_bits = &{1'b0, ld_addr[1:0], st_addr[1:0]};

  assign dmem_addr  = r_addr;
  assign dmem_rmask = r_rmask;
  assign dmem_wmask = r_wmask;
  assign dmem_wdata = r_wdata;

  always_comb begin
    w_state_nxt   = r_state;
    w_kill_nxt    = r_kill;
    w_addr_nxt    = r_addr;
    w_rmask_nxt   = r_rmask;
    w_wmask_nxt   = r_wmask;
    w_wdata_nxt   = r_wdata;
    w_st_grant    = 1'b0;
    w_ld_grant    = 1'b0;
    ld_ready      = 1'b0;
    ld_resp_valid = 1'b0;
    ld_rdata      = '0;
    st_ren        = 1'b0;
    unique case (r_state)
      IDLE: begin
        // A full FIFO or an exhausted starvation budget forces the store ahead.
        if (w_st_pend && (!w_ld_vld || st_full || r_starve_cnt == LIMIT)) begin
          w_st_grant  = 1'b1;
          w_state_nxt = ST_WAIT;
          w_addr_nxt  = {st_addr[31:2], 2'b00};
          w_wmask_nxt = st_wmask;
          w_wdata_nxt = st_wdata;
          w_rmask_nxt = '0;
        end else if (w_ld_vld) begin
          w_ld_grant  = 1'b1;
          ld_ready    = 1'b1;
          w_state_nxt = LD_WAIT;
          w_addr_nxt  = {ld_addr[31:2], 2'b00};
          w_rmask_nxt = ld_rmask;
          w_wmask_nxt = '0;
        end
      end
      LD_WAIT: begin
        if (dmem_resp) begin
          if (!r_kill && !ld_flush) begin
            ld_resp_valid = 1'b1;
            ld_rdata      = dmem_rdata;
          end
          w_rmask_nxt = '0;
          w_wmask_nxt = '0;
          w_kill_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else if (ld_flush) begin
          w_kill_nxt = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem_resp) begin
          st_ren      = 1'b1;
          w_rmask_nxt = '0;
          w_wmask_nxt = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_starve_nxt = r_starve_cnt;
    if (st_empty || w_st_grant)
      w_starve_nxt = '0;
    else if (w_ld_grant && r_starve_cnt != LIMIT)
      w_starve_nxt = r_starve_cnt + CNT_W'(1);

    // Handshake strobes stay quiet while reset is held.
    if (rst) begin
      ld_ready      = 1'b0;
      ld_resp_valid = 1'b0;
      ld_rdata      = '0;
      st_ren        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_kill       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_kill       <= w_kill_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_rmask <= '0;
      r_wmask <= '0;
      r_wdata <= '0;
    end else begin
      r_addr  <= w_addr_nxt;
      r_rmask <= w_rmask_nxt;
      r_wmask <= w_wmask_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ld_cnt    <= '0;
      perf_st_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_ld_grant)          perf_ld_cnt    <= perf_ld_cnt + 32'd1;
      if (st_ren)              perf_st_cnt    <= perf_st_cnt + 32'd1;
      if (ld_req && !ld_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter; random phase uses a
// transaction-level model (store queue, word memory, grant rules).
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ld_req, ld_flush, ld_ready, ld_resp_valid;
  logic [31:0] ld_addr, ld_rdata;
  logic [3:0]  ld_rmask;
  logic        st_empty, st_full, st_ren;
  logic [31:0] st_addr, st_wdata;
  logic [3:0]  st_wmask;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_rmask, dmem_wmask;
  logic        dmem_resp;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_ld_cnt, perf_st_cnt, perf_stall_cnt;
`endif

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_rmask(ld_rmask), .ld_ready(ld_ready),
    .ld_flush(ld_flush), .ld_resp_valid(ld_resp_valid), .ld_rdata(ld_rdata),
    .st_empty(st_empty), .st_full(st_full), .st_addr(st_addr), .st_wmask(st_wmask),
    .st_wdata(st_wdata), .st_ren(st_ren),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
`ifdef DMEM_ARB_PERF_EN
    , .perf_ld_cnt(perf_ld_cnt), .perf_st_cnt(perf_st_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct packed {logic [31:0] a; logic [3:0] m; logic [31:0] d;} st_t;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mem [int];
  st_t q[$];

  // Reference-model state for the random phase.
  int          busy, cnt, mem_wait;
  logic        killed, pop, took, mem_busy;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int k;
    k = int'(a >> 2);
    if (mem.exists(k)) return mem[k];
    return (a >> 2) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
  endfunction

  task automatic do_load(input logic [31:0] a, input logic [3:0] m, input int lat,
                         input int flush_at, input logic exp_v, input logic [31:0] d,
                         input string tag);
    drv();
    ld_req = 1'b1; ld_addr = a; ld_rmask = m; ld_flush = 1'b0; dmem_resp = 1'b0;
    smp();
    chk({tag, ".ready"}, 32'(ld_ready), 32'd1);
    for (int c = 1; c <= lat + 1; c++) begin
      drv();
      ld_req = 1'b0;
      ld_flush = (c == flush_at);
      dmem_resp = (c == lat + 1);
      dmem_rdata = dmem_resp ? d : 32'h0BAD_0BAD;
      smp();
      chk({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
      chk({tag, ".rmask"}, 32'(dmem_rmask), 32'(m));
      chk({tag, ".valid"}, 32'(ld_resp_valid), 32'((c == lat + 1) ? exp_v : 1'b0));
      if (c == lat + 1 && exp_v) chk({tag, ".rdata"}, ld_rdata, d);
    end
    drv();
    ld_flush = 1'b0; dmem_resp = 1'b0;
    smp();
    chk({tag, ".idle_rmask"}, 32'(dmem_rmask), 32'd0);
    chk({tag, ".idle_valid"}, 32'(ld_resp_valid), 32'd0);
  endtask

  task automatic model_check();
    logic st_pend, ld_v, exp_st, exp_ld, ev;
    st_pend = !st_empty;
    ld_v = ld_req && !ld_flush;
    pop = 1'b0;
    took = 1'b0;
    if (busy == 0) begin
      exp_st = st_pend && (!ld_v || st_full || cnt == LIMIT);
      exp_ld = ld_v && !exp_st;
      chk("r.ready", 32'(ld_ready), 32'(exp_ld));
      chk("r.idle_stren", 32'(st_ren), 32'd0);
      chk("r.idle_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
      if (exp_ld) begin
        busy = 1; took = 1'b1; killed = 1'b0;
        e_addr = {ld_addr[31:2], 2'b00}; e_mask = ld_rmask;
        if (st_pend && cnt < LIMIT) cnt++;
      end else if (exp_st) begin
        busy = 2;
        e_addr = {st_addr[31:2], 2'b00}; e_mask = st_wmask; e_wdata = st_wdata;
        cnt = 0;
      end
    end else begin
      chk("r.busy_ready", 32'(ld_ready), 32'd0);
      chk("r.addr", dmem_addr, e_addr);
      if (busy == 1) begin
        chk("r.ld_masks", 32'({dmem_rmask, dmem_wmask}), 32'({e_mask, 4'h0}));
        chk("r.ld_stren", 32'(st_ren), 32'd0);
        if (dmem_resp) begin
          ev = !killed && !ld_flush;
          chk("r.ld_valid", 32'(ld_resp_valid), 32'(ev));
          if (ev) chk("r.ld_rdata", ld_rdata, mem_rd(e_addr));
          busy = 0;
        end else begin
          chk("r.ld_novalid", 32'(ld_resp_valid), 32'd0);
          if (ld_flush) killed = 1'b1;
        end
      end else begin
        chk("r.st_masks", 32'({dmem_rmask, dmem_wmask}), 32'({4'h0, e_mask}));
        chk("r.st_wdata", dmem_wdata, e_wdata);
        chk("r.st_valid", 32'(ld_resp_valid), 32'd0);
        chk("r.st_ren", 32'(st_ren), 32'(dmem_resp));
        if (dmem_resp) begin
          busy = 0; pop = 1'b1;
        end
      end
    end
    if (st_empty) cnt = 0;
  endtask

  task automatic gen_inputs();
    logic [31:0] w;
    if (pop && q.size() > 0) void'(q.pop_front());
    if (q.size() < 4 && $urandom_range(0, 99) < 25)
      q.push_back('{a: 32'($urandom_range(0, 63)), m: 4'($urandom_range(1, 15)), d: $urandom});
    st_empty = (q.size() == 0);
    st_full  = (q.size() == 4);
    st_addr  = st_empty ? 32'd0 : q[0].a;
    st_wmask = st_empty ? 4'd0  : q[0].m;
    st_wdata = st_empty ? 32'd0 : q[0].d;
    if (took || ld_flush) ld_req = 1'b0;
    if (!ld_req && $urandom_range(0, 99) < 50) begin
      ld_req = 1'b1;
      ld_addr = 32'($urandom_range(0, 63));
      ld_rmask = 4'($urandom_range(1, 15));
    end
    ld_flush = ($urandom_range(0, 99) < 8);
    if (!mem_busy && (dmem_rmask != 0 || dmem_wmask != 0)) begin
      mem_busy = 1'b1;
      mem_wait = $urandom_range(0, 3);
    end
    dmem_resp = 1'b0;
    dmem_rdata = $urandom;
    if (mem_busy) begin
      if (mem_wait == 0) begin
        dmem_resp = 1'b1;
        dmem_rdata = mem_rd(dmem_addr);
        if (dmem_wmask != 0) begin
          w = mem_rd(dmem_addr);
          for (int b = 0; b < 4; b++)
            if (dmem_wmask[b]) w[8*b +: 8] = dmem_wdata[8*b +: 8];
          mem[int'(dmem_addr >> 2)] = w;
        end
        mem_busy = 1'b0;
      end else begin
        mem_wait--;
      end
    end
  endtask

  initial begin
    int pulses, g, sdone;
    int gs[2];
    logic in_st, next_addr;
    int age;

    rst = 1'b1; ld_req = 1'b0; ld_addr = '0; ld_rmask = '0; ld_flush = 1'b0;
    st_empty = 1'b1; st_full = 1'b0; st_addr = '0; st_wmask = '0; st_wdata = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (2) begin drv(); smp(); end
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.rmask", 32'(dmem_rmask), 32'd0);
    chk("rst.wmask", 32'(dmem_wmask), 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.valid", 32'(ld_resp_valid), 32'd0);
    chk("rst.rdata", ld_rdata, 32'd0);
    chk("rst.stren", 32'(st_ren), 32'd0);
    drv(); rst = 1'b0;
    smp();
    chk("idle.ready", 32'(ld_ready), 32'd0);

    do_load(32'h1006, 4'b1100, 3, -1, 1'b1, 32'hDEAD_BEEF, "load");

    // Single store.
    drv();
    st_empty = 1'b0; st_addr = 32'h2000; st_wmask = 4'hF; st_wdata = 32'h1234_5678;
    smp();
    chk("st.ready", 32'(ld_ready), 32'd0);
    chk("st.grant_ren", 32'(st_ren), 32'd0);
    pulses = 0;
    for (int c = 1; c <= 3; c++) begin
      drv(); dmem_resp = (c == 3);
      smp();
      chk("st.addr", dmem_addr, 32'h2000);
      chk("st.wmask", 32'(dmem_wmask), 32'hF);
      chk("st.wdata", dmem_wdata, 32'h1234_5678);
      chk("st.rmask", 32'(dmem_rmask), 32'd0);
      chk("st.ren", 32'(st_ren), 32'(c == 3));
      if (st_ren) pulses++;
    end
    drv(); st_empty = 1'b1; dmem_resp = 1'b0;
    smp();
    if (st_ren) pulses++;
    chk("st.idle_wmask", 32'(dmem_wmask), 32'd0);
    drv(); smp();
    if (st_ren) pulses++;
    chk("st.pulses", pulses, 32'd1);

    // Starvation bound: loads back to back with a store waiting.
    drv();
    st_empty = 1'b0; st_full = 1'b0; st_addr = 32'h3000; st_wmask = 4'b0011; st_wdata = 32'hA5A5;
    ld_req = 1'b1; ld_addr = 32'h100; ld_rmask = 4'hF; dmem_resp = 1'b0;
    g = 0; sdone = 0; in_st = 1'b0; age = 0; gs[0] = -1; gs[1] = -1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      smp();
      next_addr = ld_ready;
      if (ld_ready) g++;
      if (dmem_wmask != 0 && !in_st) begin
        in_st = 1'b1;
        gs[sdone] = g;
        g = 0;
      end
      if (st_ren) begin
        sdone++;
        in_st = 1'b0;
      end
      if (sdone == 2) break;
      drv();
      if (next_addr) ld_addr = ld_addr + 32'd4;
      if (dmem_rmask != 0 || dmem_wmask != 0) age++; else age = 0;
      dmem_resp = (age == 2);
      dmem_rdata = 32'h0;
    end
    chk("starve.done", sdone, 32'd2);
    chk("starve.first", gs[0], 32'(LIMIT));
    chk("starve.after_clear", gs[1], 32'(LIMIT));
    drv(); ld_req = 1'b0; st_empty = 1'b1; dmem_resp = 1'b0;
    smp();

    // Full FIFO beats a valid load.
    drv();
    st_empty = 1'b0; st_full = 1'b1; st_addr = 32'h4008; st_wmask = 4'b0101; st_wdata = 32'h0F0F;
    ld_req = 1'b1; ld_addr = 32'h44; ld_rmask = 4'hF;
    smp();
    chk("full.ready", 32'(ld_ready), 32'd0);
    drv(); smp();
    chk("full.wmask", 32'(dmem_wmask), 32'h5);
    chk("full.addr", dmem_addr, 32'h4008);
    chk("full.rmask", 32'(dmem_rmask), 32'd0);
    drv(); dmem_resp = 1'b1;
    smp();
    chk("full.ren", 32'(st_ren), 32'd1);
    chk("full.busy_ready", 32'(ld_ready), 32'd0);
    drv(); dmem_resp = 1'b0; st_empty = 1'b1; st_full = 1'b0;
    smp();
    chk("full.ld_after", 32'(ld_ready), 32'd1);
    drv(); ld_req = 1'b0;
    smp();
    chk("full.ld_rmask", 32'(dmem_rmask), 32'hF);
    drv(); dmem_resp = 1'b1; dmem_rdata = 32'h77;
    smp();
    chk("full.ld_valid", 32'(ld_resp_valid), 32'd1);
    chk("full.ld_rdata", ld_rdata, 32'h77);
    drv(); dmem_resp = 1'b0;
    smp();

    // Flush kills.
    do_load(32'h500, 4'hF, 3, 2, 1'b0, 32'h1111_1111, "flushA");
    do_load(32'h504, 4'b0001, 1, -1, 1'b1, 32'h2222_2222, "postkill");
    do_load(32'h508, 4'b0110, 2, 3, 1'b0, 32'h3333_3333, "flushB");
    drv(); ld_req = 1'b1; ld_flush = 1'b1; ld_addr = 32'h600; ld_rmask = 4'hF;
    smp();
    chk("flushC.ready", 32'(ld_ready), 32'd0);
    drv(); ld_req = 1'b0; ld_flush = 1'b0;
    smp();
    chk("flushC.rmask", 32'(dmem_rmask), 32'd0);
    chk("flushC.valid", 32'(ld_resp_valid), 32'd0);

    // Reset while a store is outstanding.
    drv(); st_empty = 1'b0; st_addr = 32'h700; st_wmask = 4'hF; st_wdata = 32'hCAFE;
    smp();
    drv(); smp();
    chk("rstst.wmask", 32'(dmem_wmask), 32'hF);
    drv(); rst = 1'b1;
    smp();
    chk("rstst.ren_in_rst", 32'(st_ren), 32'd0);
    drv(); rst = 1'b0; st_empty = 1'b1; ld_req = 1'b1; ld_addr = 32'h800; ld_rmask = 4'hF;
    smp();
    chk("rstst.wmask0", 32'(dmem_wmask), 32'd0);
    chk("rstst.rmask0", 32'(dmem_rmask), 32'd0);
    chk("rstst.addr0", dmem_addr, 32'd0);
    chk("rstst.wdata0", dmem_wdata, 32'd0);
    chk("rstst.ren", 32'(st_ren), 32'd0);
    chk("rstst.idle", 32'(ld_ready), 32'd1);

    // Randomized traffic against the transaction-level model.
    drv();
    rst = 1'b1; ld_req = 1'b0; ld_flush = 1'b0; st_empty = 1'b1; st_full = 1'b0; dmem_resp = 1'b0;
    smp();
    drv(); smp();
    drv();
    rst = 1'b0;
    busy = 0; cnt = 0; killed = 1'b0; pop = 1'b0; took = 1'b0; mem_busy = 1'b0; mem_wait = 0;
    q.delete();
    gen_inputs();
    repeat (3000) begin
      smp();
      model_check();
      drv();
      gen_inputs();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
